// File: rtl/seg_scan_driver_if.sv
// Load/convert handshake plus the multiplexed display lines of seg_scan_driver.
//   Value : binary cents value to convert (VAL_W bits)
//   Load  : one-cycle convert request
//   Busy  : conversion in progress
//   An    : digit enables, active-low, one-hot-low
//   Seg   : segments gfedcba, active-low
//   Dp    : decimal point, active-low
// master = the controller that issues loads and watches the display;
// slave  = the driver itself.
interface seg_scan_driver_if #(
  parameter int VAL_W = 14
);
  logic [VAL_W-1:0] Value;
  logic             Load;
  logic             Busy;
  logic [3:0]       An;
  logic [6:0]       Seg;
  logic             Dp;

  modport master (output Value, Load, input Busy, An, Seg, Dp);
  modport slave  (input Value, Load, output Busy, An, Seg, Dp);
endinterface

// File: rtl/seg_scan_driver.sv
// Seven-segment scan driver for the credit/price readout.
// A Load converts Value (saturated to 9999) to BCD with a sequential
// shift-add-3 engine; the result is latched into the display registers only
// when the conversion finishes, so the previous value keeps scanning cleanly.
// Each rising edge of the (asynchronous) ScanTick advances the digit scan by
// one position, with optional leading-zero blanking and a fixed decimal point.
// Ports:
//   Clk      : system clock
//   Rst      : asynchronous reset, active-low
//   ScanTick : ~2 kHz scan-rate square wave, asynchronous to Clk
//   Bus      : slave side of seg_scan_driver_if (Value/Load/Busy, An/Seg/Dp)
module seg_scan_driver #(
  parameter int VAL_W    = 14,
  parameter int DP_POS   = 2,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             ScanTick,
  seg_scan_driver_if.slave Bus
);
  localparam int               CNT_W   = $clog2(VAL_W);
  localparam logic [VAL_W-1:0] MAX_VAL = VAL_W'(9999);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, stateNxt;
  logic             ldEn, shEn, cpEn, busy;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      bcd, bcdAdj;
  logic [VAL_W-1:0] bin;
  logic [3:0][3:0]  disp;

  logic             sync1, sync2, prev, scanEn;
  logic [1:0]       digIdx;
  logic [3:0]       curDig;
  logic             blank, zRun;
  logic [6:0]       segDec;
  logic [3:0]       anQ;
  logic [6:0]       segQ;
  logic             dpQ;

  // ---- tick synchroniser + rising-edge detect ----
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= ScanTick;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end
  assign scanEn = sync2 & ~prev;

  // ---- converter FSM ----
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (Bus.Load) stateNxt = SHIFT;
      SHIFT:   if (cnt == CNT_W'(VAL_W - 1)) stateNxt = DONE;
      DONE:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_comb begin
    ldEn = (state == IDLE) && Bus.Load;
    shEn = (state == SHIFT);
    cpEn = (state == DONE);
    busy = (state != IDLE);
  end
  assign Bus.Busy = busy;

  // ---- shift-add-3 datapath ----
  always_comb begin
    bcdAdj = bcd;
    for (int i = 0; i < 4; i++)
      if (bcd[i*4 +: 4] >= 4'd5) bcdAdj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      bcd  <= '0;
      bin  <= '0;
      cnt  <= '0;
      disp <= '0;
    end else if (ldEn) begin
      // Saturating here keeps the 16-bit BCD field from ever overflowing.
      bin <= (Bus.Value > MAX_VAL) ? MAX_VAL : Bus.Value;
      bcd <= '0;
      cnt <= '0;
    end else if (shEn) begin
      {bcd, bin} <= {bcdAdj, bin} << 1;
      cnt        <= cnt + 1'b1;
    end else if (cpEn) begin
      disp <= bcd;
    end
  end

  // ---- digit select, blanking, decode ----
  assign curDig = disp[digIdx];

  // A digit is blanked when it is eligible and it plus every higher digit is 0.
  // Digits at or right of the decimal point are never eligible.
  always_comb begin
    blank = 1'b0;
    zRun  = 1'b1;
    if (BLANK_LZ) begin
      for (int i = 3; i >= 0; i--) begin
        zRun = zRun & (disp[i] == 4'd0);
        if (i > 0 && (DP_POS > 3 || i > DP_POS) && i == int'(digIdx)) blank = zRun;
      end
    end
  end

  always_comb begin
    case (curDig)
      4'd0:    segDec = 7'b1000000;
      4'd1:    segDec = 7'b1111001;
      4'd2:    segDec = 7'b0100100;
      4'd3:    segDec = 7'b0110000;
      4'd4:    segDec = 7'b0011001;
      4'd5:    segDec = 7'b0010010;
      4'd6:    segDec = 7'b0000010;
      4'd7:    segDec = 7'b1111000;
      4'd8:    segDec = 7'b0000000;
      4'd9:    segDec = 7'b0010000;
      default: segDec = 7'b1111111;
    endcase
  end

  // Outputs are fully registered and only move on a scan step.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      anQ    <= 4'b1111;
      segQ   <= 7'b1111111;
      dpQ    <= 1'b1;
      digIdx <= 2'd0;
    end else if (scanEn) begin
      if (blank) begin
        anQ  <= 4'b1111;
        segQ <= 7'b1111111;
        dpQ  <= 1'b1;
      end else begin
        anQ  <= ~(4'b0001 << digIdx);
        segQ <= segDec;
        dpQ  <= (int'(digIdx) == DP_POS) ? 1'b0 : 1'b1;
      end
      digIdx <= digIdx + 1'b1;
    end
  end

  assign Bus.An  = anQ;
  assign Bus.Seg = segQ;
  assign Bus.Dp  = dpQ;
endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Display back-end for the vending-machine credit/price readout.
- Sits directly downstream of the clock divider and consumes its ~2 kHz ClkOut square wave as a digit-scan rate.
- Converts a binary cents value to BCD with a sequential shift-add-3 engine.
- Drives a 4-digit, common-anode, active-low seven-segment display with decimal point and leading-zero blanking.

Parameters:
- VAL_W, 14, width of binary input Value; max displayable 9999.
- DP_POS, 2, digit index (0 = rightmost) whose decimal point lights; 4 or greater means no decimal point.
- BLANK_LZ, 1, 1 = blank leading zeros, 0 = show all digits.

Ports:
- Clk  input  1  system clock, 100 MHz.
- Rst  input  1  asynchronous, active-low reset.
- ScanTick  input  1  divider ClkOut, ~2 kHz square wave, treated as asynchronous.
- Value  input  VAL_W  binary value in cents.
- Load  input  1  one-cycle request to convert and display Value.
- Busy  output  1  conversion in progress.
- An  output  4  digit enables, active-low, one-hot-low.
- Seg  output  7  segments, active-low; Seg[0]=a … Seg[6]=g.
- Dp  output  1  decimal point, active-low.

Behaviour:
- Reset (Rst=0, asynchronous, takes effect immediately):
  - An=4'b1111, Seg=7'b1111111, Dp=1, Busy=0.
  - BCD display regs=0, digit index=0, sync/edge flops=0, FSM=IDLE.
- Tick path:
  - Two-flop synchroniser, then prev flop; scan_en = sync2 & ~prev.
  - ScanTick first sampled high at edge k → An/Seg/Dp update at edge k+2.
  - Exactly one advance per ScanTick rising edge, however long it stays high.
- Scan:
  - On scan_en, drive the current index, then index increments 0→1→2→3→0 (wrap).
  - The first scan_en after reset displays digit 0.
  - Between scan_en pulses all outputs are held (fully registered).
- Decode, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Dp=0 only when index==DP_POS.
- Blanking (BLANK_LZ=1):
  - Digit i is eligible if i>0 and (DP_POS>3 or i>DP_POS).
  - An eligible digit is blanked when it and every higher digit are 0.
  - Blanked digit: An=1111, Seg=1111111, Dp=1. The index still advances.
- Converter FSM, states IDLE, SHIFT, DONE:
  - IDLE: Load=1 at edge t → capture min(Value, 9999), clear scratch BCD, cnt=0, go to SHIFT.
  - SHIFT: each edge, add 3 to every scratch nibble ≥5, then shift {bcd, bin} left 1.
  - After 14 shifts (edges t+1..t+14; cnt==13 at edge t+14) go to DONE.
  - DONE: at edge t+15, copy scratch to display regs, go to IDLE.
  - Busy = (state != IDLE): high after edge t through edge t+15.
  - Load while Busy (including at edge t+15) is ignored, not queued. Earliest next accept is edge t+16.
  - Display regs change only in DONE, so the old value scans glitch-free during conversion.
- Width rule: the scratch register is 16 BCD bits + VAL_W binary bits; no overflow after saturation.
- Reset mid-conversion: abort to IDLE and clear all regs; the value is not displayed.

Test Plan:
- Rst low for 3 cycles mid-scan, with ScanTick toggling → An=1111, Seg=1111111, Dp=1, Busy=0 immediately; first scan after release drives An=1110.
- Load Value=1234 → Busy high exactly 15 cycles; next 4 ticks give An 1110/1101/1011/0111 with Seg 0011001/0110000/0100100/1111001; Dp=0 only with An=1011.
- Load Value=5 → digit0 Seg=0010010, digit1 and digit2 (Dp=0) show 1000000, digit3 blanked (An=1111). With BLANK_LZ=0, digit3 shows 1000000.
- Load Value=12000 → displays 9999 (all digits Seg=0010000).
- Load 1234, then Load 42 two cycles later and again at edge t+15 → both ignored, 1234 shown; Load 42 at t+16 accepted, display 0.42 after conversion.
- Hold ScanTick high for 50 cycles → one index advance only; 8 ticks → An cycles 1110→0111 twice, wrapping 3→0.
